fe_sdf_stage_ctrl: RTL

- Sequencer for one radix-2 single-delay-feedback (SDF) FFT stage in the fe datapath.
- Tracks sample position within an N-point frame and drives the stage's serial butterfly: add/sub-vs-bypass select and the −j rotation select (the butterfly's sel input).
- Also drives the D = N/2^(STG+1) feedback delay-line shift enable, zero-insertion for flushing, and output valid/start-of-frame.
- One instance per stage, placed between the frame framer and the stage datapath.

---
 rtl/fe_sdf_stage_ctrl_pkg.sv | 29 ++
 rtl/fe_sdf_stage_ctrl_if.sv | 48 ++++
 rtl/fe_sdf_stage_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fe_sdf_stage_ctrl_pkg.sv
// Shared types and helpers for the radix-2 SDF FFT stage sequencer.
// Holds the FSM state encoding, the registered output bundle and the delay-depth helper.
package fe_sdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sdf_state_t;

  typedef struct packed {
    logic dl_shift;
    logic bf_en;
    logic rot_sel;
    logic zero_ins;
    logic valid;
    logic sof;
    logic err_sof;
    logic err_flush;
    logic busy;
  } sdf_ctrl_out_t;

  // Feedback delay depth of a stage: D = N / 2^(stg+1) with N = 2^nbw_c.
  function automatic int f_dl_depth(input int nbw_c, input int stg);
    return 1 << (nbw_c - 1 - stg);
  endfunction

endpackage

// File: rtl/fe_sdf_stage_ctrl_if.sv
// Framer-side/datapath-side control bundle of one SDF stage sequencer.
// slave is the sequencer view; master is the driver (framer/bench) view.
interface fe_sdf_stage_ctrl_if;

  logic i_valid;
  logic i_sof;
  logic i_flush;
  logic o_dl_shift;
  logic o_bf_en;
  logic o_rot_sel;
  logic o_zero_ins;
  logic o_valid;
  logic o_sof;
  logic o_err_sof;
  logic o_err_flush;
  logic o_busy;

  modport slave (
    input  i_valid,
    input  i_sof,
    input  i_flush,
    output o_dl_shift,
    output o_bf_en,
    output o_rot_sel,
    output o_zero_ins,
    output o_valid,
    output o_sof,
    output o_err_sof,
    output o_err_flush,
    output o_busy
  );

  modport master (
    output i_valid,
    output i_sof,
    output i_flush,
    input  o_dl_shift,
    input  o_bf_en,
    input  o_rot_sel,
    input  o_zero_ins,
    input  o_valid,
    input  o_sof,
    input  o_err_sof,
    input  o_err_flush,
    input  o_busy
  );

endinterface

// File: rtl/fe_sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT stage: frame position counter,
// butterfly/rotation selects, delay-line enable, flush zero-insertion and output framing.
module fe_sdf_stage_ctrl
  import fe_sdf_pkg::*;
#(
  parameter int NBW_C  = 4,
  parameter int STG    = 0,
  parameter int ROT_EN = 1
) (
  input  logic               clk,
  input  logic               rst_async_n,
  fe_sdf_stage_ctrl_if.slave bus
);

  localparam int D       = f_dl_depth(NBW_C, STG);
  localparam int BF_BIT  = NBW_C - 1 - STG;
  localparam int ROT_BIT = (BF_BIT > 0) ? BF_BIT - 1 : 0;
  localparam bit ROT_ON  = (ROT_EN != 0) && (BF_BIT > 0);

  localparam logic [NBW_C-1:0] D_CNT  = NBW_C'(D);
  localparam logic [NBW_C-1:0] D_M1   = NBW_C'(D - 1);
  localparam logic [NBW_C-1:0] CNT_LAST = '1;

  sdf_state_t        state_q, state_d;
  logic [NBW_C-1:0]  cnt_q, cnt_d;
  logic              wrapped_q, wrapped_d;
  sdf_ctrl_out_t     out_q, out_d;

  logic              shift;
  logic              out_valid;
  logic              zero_ins;
  logic              err_sof;
  logic              err_flush;
  logic              rot_hit;
  logic [NBW_C-1:0]  cnt_eff;
  logic [NBW_C-1:0]  cnt_inc;

  // cnt_eff is the frame position the current shift is attributed to; a restarting
  // sof forces it to 0 so the sample becomes the first of a fresh frame.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wrapped_d = wrapped_q;
    shift     = 1'b0;
    out_valid = 1'b0;
    zero_ins  = 1'b0;
    err_sof   = 1'b0;
    err_flush = 1'b0;
    cnt_eff   = cnt_q;
    cnt_inc   = cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.i_valid && bus.i_sof) begin
          shift   = 1'b1;
          cnt_eff = '0;
          state_d = (cnt_eff == D_M1) ? RUN : FILL;
        end
      end

      FILL: begin
        if (bus.i_flush) begin
          state_d = IDLE;
        end else if (bus.i_valid) begin
          shift = 1'b1;
          if (bus.i_sof && (cnt_q != '0)) begin
            cnt_eff = '0;
            err_sof = 1'b1;
          end
          state_d = (cnt_eff == D_M1) ? RUN : FILL;
        end
      end

      RUN: begin
        if (bus.i_flush) begin
          // A sample arriving with the flush is taken as an ordinary one; alignment
          // is judged on the position that follows it.
          shift     = bus.i_valid;
          out_valid = bus.i_valid;
          state_d   = FLUSH;
          if (bus.i_valid) begin
            wrapped_d = (cnt_inc == '0);
            err_flush = (cnt_inc != '0);
          end else begin
            wrapped_d = (cnt_q == '0);
            err_flush = (cnt_q != '0);
          end
        end else if (bus.i_valid) begin
          shift = 1'b1;
          if (bus.i_sof && (cnt_q != '0)) begin
            cnt_eff = '0;
            err_sof = 1'b1;
            state_d = (cnt_eff == D_M1) ? RUN : FILL;
          end else begin
            out_valid = 1'b1;
          end
        end
      end

      FLUSH: begin
        shift     = 1'b1;
        out_valid = 1'b1;
        zero_ins  = 1'b1;
        err_flush = bus.i_valid;
        if (cnt_q == CNT_LAST) begin
          wrapped_d = 1'b1;
        end
        if (wrapped_q && (cnt_q == D_M1)) begin
          state_d   = IDLE;
          wrapped_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (shift) begin
      cnt_d = cnt_eff + 1'b1;
    end
  end

  assign rot_hit = ROT_ON & cnt_eff[BF_BIT] & cnt_eff[ROT_BIT];

  // o_sof marks output index 0 of a frame, including one reached while draining.
  always_comb begin
    out_d           = '0;
    out_d.dl_shift  = shift;
    out_d.bf_en     = shift & cnt_eff[BF_BIT];
    out_d.rot_sel   = shift & rot_hit;
    out_d.zero_ins  = zero_ins;
    out_d.valid     = out_valid;
    out_d.sof       = out_valid & (cnt_eff == D_CNT);
    out_d.err_sof   = err_sof;
    out_d.err_flush = err_flush;
    out_d.busy      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
      out_q     <= out_d;
    end
  end

  assign bus.o_dl_shift  = out_q.dl_shift;
  assign bus.o_bf_en     = out_q.bf_en;
  assign bus.o_rot_sel   = out_q.rot_sel;
  assign bus.o_zero_ins  = out_q.zero_ins;
  assign bus.o_valid     = out_q.valid;
  assign bus.o_sof       = out_q.sof;
  assign bus.o_err_sof   = out_q.err_sof;
  assign bus.o_err_flush = out_q.err_flush;
  assign bus.o_busy      = out_q.busy;

  // Structural invariants of the registered output bundle.
  a_valid_shift : assert property (@(posedge clk) disable iff (!rst_async_n)
    bus.o_valid |-> bus.o_dl_shift);
  a_zero_valid : assert property (@(posedge clk) disable iff (!rst_async_n)
    bus.o_zero_ins |-> bus.o_valid);
  a_sof_bf : assert property (@(posedge clk) disable iff (!rst_async_n)
    bus.o_sof |-> (bus.o_valid && bus.o_bf_en));
  a_rot_bf : assert property (@(posedge clk) disable iff (!rst_async_n)
    bus.o_rot_sel |-> bus.o_bf_en);

endmodule
